risc16_fetch: RTL and testbench

//  Instruction-fetch stage directly downstream of the RISC-16 PC register.
//  - Takes the current PC and issues one request at a time to instruction memory.
//  - Buffers returned words with their PC in a small FIFO and presents them to decode.
//  - Tells the PC stage when it may advance (pc_advance), and discards stale fetches on a redirect.

---
 rtl/risc16_fetch.sv | 160 ++++++++++++++++
 tb/tb_risc16_fetch.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/risc16_fetch.sv
// risc16_fetch: RISC-16 instruction-fetch stage.
// The fetch stage sits between the PC register and decode. It keeps at most one
// instruction-memory request outstanding. Returned words are buffered with their PC
// in a small FIFO, and fetches made stale by a redirect are discarded.
// Optional feature macro: RISC16_IF_BYPASS_EN. When it is defined, a response that
// arrives while the buffer is empty and decode is ready goes straight to decode,
// without passing through the FIFO.
module risc16_fetch #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               flush,
    output logic               pc_advance,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               if_ready
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDrop
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [INSTR_W-1:0]  mem_instr_q [DEPTH];
    logic [ADDR_W-1:0]   mem_pc_q    [DEPTH];
    logic [INSTR_W-1:0]  hold_instr_q;
    logic [ADDR_W-1:0]   hold_pc_q;

    logic                issue;
    logic                rsp_take;
    logic                bypass;
    logic                push;
    logic                pop;
    logic                full;
    logic                fifo_valid;
    logic [INSTR_W-1:0]  head_instr;
    logic [ADDR_W-1:0]   head_pc;

    assign full       = (count_q == CntW'(DEPTH));
    assign fifo_valid = (count_q != '0) && !flush;
    assign pop        = fifo_valid && if_ready;

`ifdef RISC16_IF_BYPASS_EN
    assign bypass = rsp_take && (count_q == '0) && if_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = rsp_take && !bypass;

    // When the FIFO is empty the last presented word is held on if_instr/if_pc.
    assign head_instr = (count_q != '0) ? mem_instr_q[rd_ptr_q] : hold_instr_q;
    assign head_pc    = (count_q != '0) ? mem_pc_q[rd_ptr_q]    : hold_pc_q;

    // Next-state logic for the request FSM; a slot is reserved when the request issues.
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        issue    = 1'b0;
        rsp_take = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!flush && !full) begin
                    issue    = 1'b1;
                    req_pc_d = pc_in;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (flush) begin
                    state_d = imem_rvalid ? StIdle : StDrop;
                end else if (imem_rvalid) begin
                    rsp_take = 1'b1;
                    state_d  = StIdle;
                end
            end
            StDrop: begin
                // The single outstanding response retires the drop even alongside a flush.
                if (imem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO occupancy and pointer update; a flush empties the buffer and ignores any pop.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d = count_q + CntW'(push) - CntW'(pop);
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    // Outputs; the request and advance strobes are masked while reset is asserted.
    always_comb begin
        imem_req   = issue && !reset;
        imem_addr  = imem_req ? pc_in : '0;
        pc_advance = (issue || flush) && !reset;
        if_valid   = fifo_valid || bypass;
        if_instr   = bypass ? imem_rdata : head_instr;
        if_pc      = bypass ? req_pc_q   : head_pc;
    end

    // State, pointers and hold registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            req_pc_q     <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            hold_instr_q <= if_instr;
            hold_pc_q    <= if_pc;
        end
    end

    // Buffer storage; contents are only observed through count_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_risc16_fetch.sv
// tb_risc16_fetch: directed, table-driven bench for risc16_fetch (default build).
// Inputs change on the falling edge, and outputs are checked 1 ns later.
module tb_risc16_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_in;
    logic        flush;
    logic        pc_advance;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_ready;

    int checks   = 0;
    int failures = 0;
    int row      = 0;

    always #5 clk = ~clk;

    risc16_fetch #(
        .DEPTH  (2),
        .ADDR_W (16),
        .INSTR_W(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .flush      (flush),
        .pc_advance (pc_advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_ready   (if_ready)
    );

    typedef struct {
        logic        rst;
        logic        fl;
        logic        rv;
        logic [15:0] rdata;
        logic        rdy;
        logic [15:0] pc;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_adv;
        logic        e_val;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic fl, input logic rv,
                                input logic [15:0] rdata, input logic rdy,
                                input logic [15:0] pc, input logic e_req,
                                input logic [15:0] e_addr, input logic e_adv,
                                input logic e_val, input logic [15:0] e_instr,
                                input logic [15:0] e_pc);
        vec_t v;
        v.rst = rst; v.fl = fl; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.pc = pc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_adv = e_adv; v.e_val = e_val;
        v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        reset       = v.rst;
        flush       = v.fl;
        imem_rvalid = v.rv;
        imem_rdata  = v.rdata;
        if_ready    = v.rdy;
        pc_in       = v.pc;
        #1;
        chk("imem_req", {15'd0, imem_req}, {15'd0, v.e_req});
        if (v.e_req || v.rst) chk("imem_addr", imem_addr, v.e_addr);
        chk("pc_advance", {15'd0, pc_advance}, {15'd0, v.e_adv});
        chk("if_valid", {15'd0, if_valid}, {15'd0, v.e_val});
        chk("if_instr", if_instr, v.e_instr);
        chk("if_pc", if_pc, v.e_pc);
        row++;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        if_ready = 1'b0; pc_in = '0;

        //          rst fl rv rdata     rdy pc      | req addr     adv val instr     pc
        // Reset held: everything 0, even with a flush and a nonzero PC
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000));
        // First fetch and 1-cycle latency, then fill the buffer with decode stalled
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 16'hA123, 0, 16'h0001, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0001, 1, 16'h0001, 1, 1, 16'hA123, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 16'hB001, 0, 16'h0002, 0, 16'h0000, 0, 1, 16'hA123, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0002, 0, 16'h0000, 0, 1, 16'hA123, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0002, 0, 16'h0000, 0, 1, 16'hA123, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0002, 1, 16'h0002, 1, 1, 16'hB001, 16'h0001));
        // Flush in WAIT, flush again in DROP, late response discarded, refetch at 0x40
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0005, 0, 16'h0000, 1, 0, 16'hB001, 16'h0001));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 1, 0, 16'hB001, 16'h0001));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 0, 0, 16'hB001, 16'h0001));
        vecs.push_back(mk(0, 0, 1, 16'hDEAD, 1, 16'h0040, 0, 16'h0000, 0, 0, 16'hB001, 16'h0001));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0040, 1, 16'h0040, 1, 0, 16'hB001, 16'h0001));
        // Flush together with rvalid: nothing pushed, back to IDLE
        vecs.push_back(mk(0, 1, 1, 16'hC040, 1, 16'h0041, 0, 16'h0000, 1, 0, 16'hB001, 16'h0001));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0080, 1, 16'h0080, 1, 0, 16'hB001, 16'h0001));
        vecs.push_back(mk(0, 0, 1, 16'hC080, 1, 16'h0081, 0, 16'h0000, 0, 0, 16'hB001, 16'h0001));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0081, 1, 16'h0081, 1, 1, 16'hC080, 16'h0080));
        vecs.push_back(mk(0, 0, 1, 16'hC081, 0, 16'h0082, 0, 16'h0000, 0, 1, 16'hC080, 16'h0080));
        // Flush together with a pop on a 2-entry buffer: empty afterwards
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0082, 0, 16'h0000, 1, 0, 16'hC080, 16'h0080));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0090, 1, 16'h0090, 1, 0, 16'hC080, 16'h0080));
        vecs.push_back(mk(0, 0, 1, 16'hD090, 0, 16'h0091, 0, 16'h0000, 0, 0, 16'hC080, 16'h0080));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0091, 1, 16'h0091, 1, 1, 16'hD090, 16'h0090));
        // Async reset while a request is outstanding with an entry buffered
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0092, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 1, 16'hEEEE, 0, 16'h0092, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000));
        // Late rvalid in IDLE after release is not buffered
        vecs.push_back(mk(0, 0, 1, 16'hEEEE, 1, 16'h0010, 1, 16'h0010, 1, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0011, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 16'hF010, 1, 16'h0011, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0011, 1, 16'h0011, 1, 1, 16'hF010, 16'h0010));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Pointer wrap: six fetch/pop pairs after a fresh reset
        step(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000));
        for (int k = 0; k < 6; k++) begin
            logic [15:0] pk;
            logic [15:0] ei;
            logic [15:0] ep;
            pk = 16'(k);
            ei = (k > 0) ? 16'h5000 + pk - 16'd1 : 16'h0000;
            ep = (k > 0) ? pk - 16'd1 : 16'h0000;
            step(mk(0, 0, 0, 16'h0000, 1, pk, 1, pk, 1, (k > 0), ei, ep));
            step(mk(0, 0, 1, 16'h5000 + pk, 1, pk + 16'd1, 0, 16'h0000, 0, 0, ei, ep));
        end
        step(mk(0, 0, 0, 16'h0000, 1, 16'h0006, 1, 16'h0006, 1, 1, 16'h5005, 16'h0005));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
